// File: rtl/cbf_loop_codeblock.sv
// Stutterable program-step model of a bounds-checked array access with constant-branch folding.
// MODE=0 keeps the folded branch step (source); MODE=1 removes it (target).
module cbf_loop_codeblock #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stutter_in,
  input  logic [IDX_W-1:0]        j,
  input  logic [IDX_W-1:0]        arr_size,
  input  logic [DEPTH*DATA_W-1:0] arr,
  output logic [DATA_W-1:0]       a,
  output logic [DATA_W-1:0]       b,
  output logic                    stutter,
  output logic [3:0]              pc,
  output logic                    done
);

  localparam logic [3:0] S_INIT  = 4'd0;
  localparam logic [3:0] S_COND  = 4'd1;
  localparam logic [3:0] S_LOAD  = 4'd2;
  localparam logic [3:0] S_LOOP  = 4'd3;
  localparam logic [3:0] S_FOLD  = 4'd4;
  localparam logic [3:0] S_LOAD2 = 4'd5;
  localparam logic [3:0] S_CLAMP = 4'd6;
  localparam logic [3:0] S_DEAD1 = 4'd7;
  localparam logic [3:0] S_DEAD2 = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [IDX_W-1:0] i;

  // Array read with the out-of-range rule: any index at or beyond DEPTH reads as zero.
  function automatic logic [DATA_W-1:0] elem(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(idx) == k) val = arr[k*DATA_W +: DATA_W];
    end
    return val;
  endfunction

  assign done = (pc == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= S_INIT;
      a       <= '0;
      b       <= '0;
      i       <= '0;
      stutter <= 1'b0;
    end else begin
      stutter <= stutter_in;
      if (!stutter_in) begin
        case (pc)
          S_INIT: begin
            a  <= '0;
            b  <= '0;
            i  <= '0;
            pc <= S_COND;
          end
          S_COND: begin
            if (j <= arr_size) pc <= S_LOAD;
            else               pc <= (MODE == 0) ? S_FOLD : S_LOAD2;
          end
          S_LOAD: begin
            a  <= elem('0);
            i  <= '0;
            pc <= S_LOOP;
          end
          S_LOOP: begin
            b <= b + elem(i);
            if (i == j) pc <= S_DONE;
            else        i  <= i + IDX_W'(1);
          end
          S_FOLD:  pc <= S_LOAD2;
          S_LOAD2: begin
            a  <= elem('0);
            pc <= S_CLAMP;
          end
          S_CLAMP: begin
            b  <= elem(arr_size);
            pc <= S_DONE;
          end
          // Steps 7/8 are kept encoded for the case study but nothing branches to them.
          S_DEAD1: begin
            a  <= elem('0);
            pc <= S_DEAD2;
          end
          S_DEAD2: begin
            b  <= elem('0);
            pc <= S_DONE;
          end
          S_DONE:  pc <= S_DONE;
          default: pc <= S_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cbf_loop_codeblock.sv
// Self-checking bench: source (MODE=0) and target (MODE=1) run side by side,
// plus a DEPTH=3/IDX_W=3 instance exercising out-of-range reads.
module tb_cbf_loop_codeblock;

  logic       clk = 1'b0;
  logic       rst, stutter_in;
  logic [1:0] j, arr_size;
  logic [7:0] arr;
  logic [1:0] a0, b0, a1, b1;
  logic [3:0] pc0, pc1;
  logic       st0, st1, done0, done1;

  logic       rst2, stutter_in2;
  logic [2:0] j2, arr_size2;
  logic [5:0] arr2;
  logic [1:0] a2, b2;
  logic [3:0] pc2;
  logic       st2, done2;

  int tests_run = 0;
  int tests_failed = 0;
  int m_vals[8];
  int m_depth;

  always #5 clk = ~clk;

  cbf_loop_codeblock #(.DATA_W(2), .DEPTH(4), .IDX_W(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in), .j(j), .arr_size(arr_size), .arr(arr),
    .a(a0), .b(b0), .stutter(st0), .pc(pc0), .done(done0));

  cbf_loop_codeblock #(.DATA_W(2), .DEPTH(4), .IDX_W(2), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in), .j(j), .arr_size(arr_size), .arr(arr),
    .a(a1), .b(b1), .stutter(st1), .pc(pc1), .done(done1));

  cbf_loop_codeblock #(.DATA_W(2), .DEPTH(3), .IDX_W(3), .MODE(0)) dut2 (
    .clk(clk), .rst(rst2), .stutter_in(stutter_in2), .j(j2), .arr_size(arr_size2), .arr(arr2),
    .a(a2), .b(b2), .stutter(st2), .pc(pc2), .done(done2));

  // Program outcome straight from the source-level semantics.
  function automatic void ref_model(input int jj, input int sz, input int mode,
                                    output logic [1:0] ea, output logic [1:0] eb, output int lat);
    int sum;
    ea = logic'(0);
    ea = 2'(m_vals[0]);
    if (jj <= sz) begin
      sum = 0;
      for (int k = 0; k <= jj; k++) sum += (k < m_depth) ? m_vals[k] : 0;
      eb  = 2'(sum % 4);
      lat = 4 + jj;
    end else begin
      eb  = 2'((sz < m_depth) ? m_vals[sz] : 0);
      lat = (mode == 1) ? 4 : 5;
    end
  endfunction

  task automatic fail(input string name, input int got, input int exp);
    tests_failed++;
    $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic run_a(input logic [1:0] jj, input logic [1:0] sz, input logic [7:0] av,
                       input logic [31:0] st_mask, input int st_pct, input string tag);
    logic [1:0] ea, eb;
    int lat0, lat1, active, edges, target;
    bit saw4_0, saw4_1, oob;
    j = jj; arr_size = sz; arr = av;
    m_depth = 4;
    for (int k = 0; k < 4; k++) m_vals[k] = int'(av[k*2 +: 2]);
    ref_model(int'(jj), int'(sz), 0, ea, eb, lat0);
    ref_model(int'(jj), int'(sz), 1, ea, eb, lat1);
    oob = (jj > sz);
    rst = 1'b1; stutter_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    active = 0; edges = 0; saw4_0 = 0; saw4_1 = 0;
    target = ((lat0 > lat1) ? lat0 : lat1) + 2;
    while (active < target && edges < 80) begin
      edges++;
      stutter_in = (edges < 32) ? st_mask[edges[4:0]] : 1'b0;
      if ($urandom_range(99) < st_pct) stutter_in = 1'b1;
      @(posedge clk); #1;
      if (!stutter_in) active++;
      tests_run++;
      if (st0 !== stutter_in) fail({tag, " stutter0"}, int'(st0), int'(stutter_in));
      tests_run++;
      if (st1 !== stutter_in) fail({tag, " stutter1"}, int'(st1), int'(stutter_in));
      tests_run++;
      if (done0 !== (active >= lat0)) fail({tag, " done0"}, int'(done0), int'(active >= lat0));
      tests_run++;
      if (done1 !== (active >= lat1)) fail({tag, " done1"}, int'(done1), int'(active >= lat1));
      if (pc0 == 4'd4) saw4_0 = 1;
      if (pc1 == 4'd4) saw4_1 = 1;
    end
    tests_run++;
    if (edges >= 80) fail({tag, " timeout"}, edges, 80);
    tests_run++;
    if (a0 !== ea) fail({tag, " a0"}, int'(a0), int'(ea));
    tests_run++;
    if (b0 !== eb) fail({tag, " b0"}, int'(b0), int'(eb));
    tests_run++;
    if (a1 !== ea) fail({tag, " a1"}, int'(a1), int'(ea));
    tests_run++;
    if (b1 !== eb) fail({tag, " b1"}, int'(b1), int'(eb));
    tests_run++;
    if (saw4_0 !== oob) fail({tag, " fold0"}, int'(saw4_0), int'(oob));
    tests_run++;
    if (saw4_1 !== 1'b0) fail({tag, " fold1"}, int'(saw4_1), 0);
  endtask

  task automatic run_b(input logic [2:0] jj, input logic [2:0] sz, input logic [5:0] av,
                       input int st_pct, input string tag);
    logic [1:0] ea, eb;
    int lat, active, edges;
    j2 = jj; arr_size2 = sz; arr2 = av;
    m_depth = 3;
    for (int k = 0; k < 8; k++) m_vals[k] = (k < 3) ? int'(av[k*2 +: 2]) : 0;
    ref_model(int'(jj), int'(sz), 0, ea, eb, lat);
    rst2 = 1'b1; stutter_in2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0;
    active = 0; edges = 0;
    while (active < lat + 2 && edges < 80) begin
      edges++;
      stutter_in2 = ($urandom_range(99) < st_pct);
      @(posedge clk); #1;
      if (!stutter_in2) active++;
      tests_run++;
      if (st2 !== stutter_in2) fail({tag, " stutter2"}, int'(st2), int'(stutter_in2));
      tests_run++;
      if (done2 !== (active >= lat)) fail({tag, " done2"}, int'(done2), int'(active >= lat));
    end
    tests_run++;
    if (edges >= 80) fail({tag, " timeout"}, edges, 80);
    tests_run++;
    if (a2 !== ea) fail({tag, " a2"}, int'(a2), int'(ea));
    tests_run++;
    if (b2 !== eb) fail({tag, " b2"}, int'(b2), int'(eb));
    rst2 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stutter_in = 1'b1; j = 2'd1; arr_size = 2'd3; arr = 8'hFF;
    @(posedge clk); #1;
    tests_run++;
    if (pc0 !== 4'd0) fail("reset pc", int'(pc0), 0);
    tests_run++;
    if (a0 !== 2'd0 || b0 !== 2'd0) fail("reset a/b", int'({a0, b0}), 0);
    tests_run++;
    if (st0 !== 1'b0) fail("reset stutter", int'(st0), 0);
    tests_run++;
    if (done0 !== 1'b0 || done1 !== 1'b0) fail("reset done", int'({done0, done1}), 0);
    stutter_in = 1'b0;
  endtask

  task automatic test_pc_sequence();
    int exp_pc[5] = '{1, 2, 3, 3, 9};
    j = 2'd1; arr_size = 2'd3; arr = {2'd3, 2'd2, 2'd1, 2'd1};
    rst = 1'b1; stutter_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (pc0 !== 4'd0) fail("seq pc start", int'(pc0), 0);
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (int'(pc0) != exp_pc[e]) fail("seq pc", int'(pc0), exp_pc[e]);
    end
  endtask

  task automatic test_mid_reset();
    j = 2'd3; arr_size = 2'd3; arr = {2'd3, 2'd2, 2'd1, 2'd1};
    rst = 1'b1; stutter_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (pc0 !== 4'd0 || pc1 !== 4'd0) fail("midrst pc", int'(pc0), 0);
    tests_run++;
    if (a0 !== 2'd0 || b0 !== 2'd0) fail("midrst a/b", int'({a0, b0}), 0);
    repeat (6) begin @(posedge clk); #1; end
    tests_run++;
    if (done0 !== 1'b0) fail("midrst early done", int'(done0), 0);
    @(posedge clk); #1;
    tests_run++;
    if (done0 !== 1'b1 || done1 !== 1'b1) fail("midrst done", int'({done0, done1}), 3);
    tests_run++;
    if (a0 !== 2'd1 || b0 !== 2'd3) fail("midrst result", int'({a0, b0}), int'({2'd1, 2'd3}));
  endtask

  task automatic test_in_bounds();
    run_a(2'd1, 2'd3, {2'd3, 2'd2, 2'd1, 2'd1}, 32'h0, 0, "inb j1");
    run_a(2'd3, 2'd3, {2'd3, 2'd2, 2'd1, 2'd1}, 32'h0, 0, "inb j3");
    run_a(2'd0, 2'd0, {2'd0, 2'd1, 2'd2, 2'd3}, 32'h0, 0, "inb j0");
  endtask

  task automatic test_out_of_bounds();
    run_a(2'd3, 2'd2, {2'd3, 2'd2, 2'd1, 2'd1}, 32'h0, 0, "oob");
    run_a(2'd2, 2'd0, {2'd2, 2'd1, 2'd0, 2'd3}, 32'h0, 0, "oob sz0");
  endtask

  task automatic test_stutter();
    run_a(2'd1, 2'd3, {2'd3, 2'd2, 2'd1, 2'd1}, 32'h0000_000C, 0, "stutter");
  endtask

  task automatic test_out_of_range_read();
    run_b(3'd5, 3'd3, {2'd2, 2'd1, 2'd1}, 0, "oor j5");
    run_b(3'd5, 3'd6, {2'd2, 2'd1, 2'd3}, 0, "oor loop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_a(2'($urandom), 2'($urandom), 8'($urandom), 32'h0, 30, "rand A");
    for (int n = 0; n < 30; n++)
      run_b(3'($urandom), 3'($urandom), 6'($urandom), 30, "rand B");
  endtask

  initial begin
    rst2 = 1'b1; stutter_in2 = 1'b0; j2 = '0; arr_size2 = '0; arr2 = '0;
    test_reset();
    test_pc_sequence();
    test_in_bounds();
    test_out_of_bounds();
    test_stutter();
    test_mid_reset();
    test_out_of_range_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cbf_loop_codeblock.md
Name: cbf_loop_codeblock

Overview:
- Parametrised, stutterable program-step model of a bounds-checked array access with constant-branch folding, used as the source/target pair in the cbf/dbe asynchronous-hyperLTL case study.
- Executes a small fixed program: in-bounds path accumulates arr[0..j] into b; out-of-bounds path clamps to arr[arr_size].
- MODE selects whether the folded constant-branch step is still executed (source) or eliminated (target). Outputs a/b must match across modes; step counts must differ.

Parameters:
- DATA_W, 2: element and output width.
- DEPTH, 4: number of array elements.
- IDX_W, 2: width of j, arr_size and the loop index.
- MODE, 0: 0 = source, executes fold step 4; 1 = target, step 4 removed.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- stutter_in  in  1  1 = freeze program this cycle.
- j  in  IDX_W  requested index.
- arr_size  in  IDX_W  bound.
- arr  in  DEPTH*DATA_W  flattened array; element k = arr[k*DATA_W +: DATA_W].
- a  out  DATA_W  registered result a.
- b  out  DATA_W  registered result b / accumulator.
- stutter  out  1  registered copy of stutter_in.
- pc  out  4  current program step.
- done  out  1  combinational, high iff pc==9.

Behaviour:
- Reset (rst=1 at posedge) has priority over everything: pc=0, a=0, b=0, i=0, stutter=0. Mid-program reset aborts the run; the next run restarts from step 0.
- Every non-reset posedge: stutter <= stutter_in. If stutter_in=1, pc, a, b and i hold.
- Element read rule: index >= DEPTH returns 0. Addition wraps mod 2^DATA_W; no saturation.
- Step 0 INIT: a<=0, b<=0, i<=0; go to 1.
- Step 1 COND: if j<=arr_size (unsigned), go to 2. Otherwise go to 4 when MODE=0, or to 5 when MODE=1.
- Step 2 LOAD: a<=arr[0], i<=0; go to 3.
- Step 3 LOOP: b<=b+arr[i]. If i==j, go to 9; else i<=i+1 and stay in 3. i never exceeds j, so no wrap.
- Step 4 FOLD: constant-true branch, go to 5. Steps 7/8 stay encoded but are unreachable.
- Step 5 LOAD2: a<=arr[0]; go to 6.
- Step 6 CLAMP: b<=arr[arr_size]; go to 9.
- Step 7 DEAD: a<=arr[0]; go to 8.
- Step 8 DEAD: b<=arr[0]; go to 9.
- Step 9 DONE: terminal. a and b hold until reset.
- Encodings 10-15 are illegal; they go to 9 with no output change.
- Latency, counted in non-stutter posedges after reset release:
  - in-bounds: 4+j;
  - out-of-bounds: 5 (MODE=0) or 4 (MODE=1).
- Stutter cycles add exactly one cycle each.
- Inputs j, arr_size and arr are sampled live each step. Holding them stable for a run is the bench's responsibility.

Test Plan:
Defaults DATA_W=2, DEPTH=4, IDX_W=2; arr elements [1,1,2,3].
- j=1, arr_size=3, no stutter -> a=1, b=2, done after 5 posedges, pc sequence 0,1,2,3,3,9.
- j=3, arr_size=2 -> a=1, b=2 (clamp). MODE=0: done after 5, pc passes through 4. MODE=1: done after 4, pc never 4.
- j=3, arr_size=3 -> b=(1+1+2+3) mod 4 = 3, a=1, done after 7.
- First test, stutter_in=1 on posedges 2-3 -> pc/a/b frozen on those edges, stutter=1 one cycle later, done after 7, same a=1, b=2.
- Third test, rst=1 on posedge 5 (in LOOP) -> next cycle pc=0, a=0, b=0; after release, result a=1, b=3 after 7 more posedges.
- DEPTH=3, IDX_W=3, arr elements [1,1,2], arr_size=3, j=5 -> out-of-bounds path, b=arr[3]=0 (out-of-range read), a=1.
